// File: rtl/memory_responder_if.sv
// Request/response bus between the CPU address/data path and the memory responder.
// The CPU side drives the in_* request fields; the responder drives the out_* fields.
interface memory_responder_if;
    logic [31:0] in_address;
    logic [31:0] in_wdata;
    logic [3:0]  in_byte_en;
    logic        in_write;
    logic        in_request;
    logic [31:0] out_rdata;
    logic        out_ready;
    logic        out_error;
    logic        out_busy;

    modport master (
        output in_address, in_wdata, in_byte_en, in_write, in_request,
        input  out_rdata, out_ready, out_error, out_busy
    );

    modport slave (
        input  in_address, in_wdata, in_byte_en, in_write, in_request,
        output out_rdata, out_ready, out_error, out_busy
    );
endinterface

// File: rtl/memory_responder.sv
// Memory-side responder: serves word reads and byte-masked writes from an internal RAM
// after WAIT_STATES idle cycles, then signals completion with a one-cycle ready pulse.
// Misaligned or out-of-range accesses complete with error set and leave the RAM untouched.
module memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                reset,
    memory_responder_if.slave   bus
);

    localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic        busy_q, busy_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Fields of the access being performed this edge. With zero wait states the access
    // happens on the acceptance edge itself, so the live inputs are used in IDLE.
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_wr;
    logic        acc_err;
    logic [AW-1:0] acc_idx;
    logic        enter_resp;
    logic        mem_we;

    // Select live or latched request fields and classify the access
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr  = bus.in_address;
            acc_wdata = bus.in_wdata;
            acc_be    = bus.in_byte_en;
            acc_wr    = bus.in_write;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
            acc_wr    = wr_q;
        end
        acc_err = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= LIMIT);
        acc_idx = acc_addr[AW+1:2];
    end

    // Next-state and next-output computation for the request FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_request) begin
                    addr_d  = bus.in_address;
                    wdata_d = bus.in_wdata;
                    be_d    = bus.in_byte_en;
                    wr_d    = bus.in_write;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESPOND;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESPOND;
                    enter_resp = 1'b1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_resp) begin
            ready_d = 1'b1;
            error_d = acc_err;
            rdata_d = (acc_err || acc_wr) ? '0 : mem[acc_idx];
        end

        busy_d = (state_d != S_IDLE);
    end

    // RAM write happens on the edge that enters RESPOND; a reset on that edge aborts it
    assign mem_we = enter_resp && acc_wr && !acc_err && !reset;

    // Request FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    // Byte-lane masked RAM write; contents are not affected by reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.out_rdata = rdata_q;
    assign bus.out_ready = ready_q;
    assign bus.out_error = error_q;
    assign bus.out_busy  = busy_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance with two wait states for latency,
// data, masking, error and reset-abort cases, and one with zero wait states for
// back-to-back acceptance and requests arriving during RESPOND.
module tb_memory_responder;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    memory_responder_if bus2 ();
    memory_responder_if bus0 ();

    memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One access on the two-wait-state instance; returns data, error and latency in edges
    // counted from the acceptance edge, and checks the ready pulse is one cycle wide.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic wr, output logic [31:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        bus2.in_address = a;
        bus2.in_wdata   = wd;
        bus2.in_byte_en = be;
        bus2.in_write   = wr;
        bus2.in_request = 1'b1;
        @(posedge clk); #1;
        bus2.in_request = 1'b0;
        bus2.in_wdata   = 32'h0BAD_0BAD;
        lat = 0;
        while (!bus2.out_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = bus2.out_rdata;
        er = bus2.out_error;
        @(posedge clk); #1;
        check("ready_width", {31'b0, bus2.out_ready}, 32'd0);
        check("busy_after", {31'b0, bus2.out_busy}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [7:0]  rdy_pat;
    logic        saw_ready;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus2.in_address = '0; bus2.in_wdata = '0; bus2.in_byte_en = '0;
        bus2.in_write = 1'b0; bus2.in_request = 1'b0;
        bus0.in_address = '0; bus0.in_wdata = '0; bus0.in_byte_en = '0;
        bus0.in_write = 1'b0; bus0.in_request = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, bus2.out_ready}, 32'd0);
        check("rst_error", {31'b0, bus2.out_error}, 32'd0);
        check("rst_rdata", bus2.out_rdata, 32'd0);
        check("rst_busy",  {31'b0, bus2.out_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1) Read 0x0: ready two edges after acceptance
        access(32'h0, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("rd0_latency", 32'(lat), 32'd2);
        check("rd0_error", {31'b0, er}, 32'd0);

        // 2) Full-word write then read back
        access(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd, er, lat);
        check("wr10_latency", 32'(lat), 32'd2);
        check("wr10_error", {31'b0, er}, 32'd0);
        check("wr10_rdata", rd, 32'd0);
        access(32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("rd10_rdata", rd, 32'hDEADBEEF);
        check("rd10_error", {31'b0, er}, 32'd0);

        // 3) Lanes 0 and 2 only
        access(32'h10, 32'h11223344, 4'b0101, 1'b1, rd, er, lat);
        access(32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("rd10_masked", rd, 32'hDE22BE44);

        // byte_en 0 write: legal no-op that still completes
        access(32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1, rd, er, lat);
        check("wr_noop_latency", 32'(lat), 32'd2);
        check("wr_noop_error", {31'b0, er}, 32'd0);
        access(32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("rd10_after_noop", rd, 32'hDE22BE44);

        // 4) Error accesses
        access(32'h13, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("mis_error", {31'b0, er}, 32'd1);
        check("mis_rdata", rd, 32'd0);
        check("mis_latency", 32'(lat), 32'd2);
        access(32'h1000, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("oor_error", {31'b0, er}, 32'd1);
        check("oor_rdata", rd, 32'd0);
        access(32'h1010, 32'h0, 4'hF, 1'b1, rd, er, lat);
        check("oor_wr_error", {31'b0, er}, 32'd1);
        access(32'h8000_0010, 32'h0, 4'hF, 1'b1, rd, er, lat);
        check("hi_wr_error", {31'b0, er}, 32'd1);
        access(32'h11, 32'h0, 4'hF, 1'b1, rd, er, lat);
        check("mis_wr_error", {31'b0, er}, 32'd1);
        access(32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("rd10_unchanged", rd, 32'hDE22BE44);

        // Last valid word
        access(32'hFFC, 32'hA5A5_0FF0, 4'hF, 1'b1, rd, er, lat);
        check("wr_top_error", {31'b0, er}, 32'd0);
        access(32'hFFC, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("rd_top_rdata", rd, 32'hA5A5_0FF0);
        check("rd_top_error", {31'b0, er}, 32'd0);

        // 5) Reset during WAIT of a write aborts it
        access(32'h20, 32'hCAFEF00D, 4'hF, 1'b1, rd, er, lat);
        @(negedge clk);
        bus2.in_address = 32'h20; bus2.in_wdata = 32'h0; bus2.in_byte_en = 4'hF;
        bus2.in_write = 1'b1; bus2.in_request = 1'b1;
        @(posedge clk); #1;
        bus2.in_request = 1'b0;
        check("abort_busy_wait", {31'b0, bus2.out_busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        saw_ready = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_cleared", {31'b0, bus2.out_busy}, 32'd0);
        saw_ready = saw_ready | bus2.out_ready;
        repeat (3) begin
            @(posedge clk); #1;
            saw_ready = saw_ready | bus2.out_ready;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            saw_ready = saw_ready | bus2.out_ready;
        end
        check("abort_no_ready", {31'b0, saw_ready}, 32'd0);
        access(32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("abort_word_kept", rd, 32'hCAFEF00D);

        // 6) Zero wait states: write, then a request during RESPOND is dropped
        @(negedge clk);
        bus0.in_address = 32'h8; bus0.in_wdata = 32'h5A5A5A5A; bus0.in_byte_en = 4'hF;
        bus0.in_write = 1'b1; bus0.in_request = 1'b1;
        @(posedge clk); #1;
        bus0.in_request = 1'b0;
        check("w0_wr_ready", {31'b0, bus0.out_ready}, 32'd1);
        @(posedge clk); #1;
        check("w0_wr_ready_width", {31'b0, bus0.out_ready}, 32'd0);

        @(negedge clk);
        bus0.in_write = 1'b0; bus0.in_request = 1'b1;
        @(posedge clk); #1;
        check("w0_rd_ready", {31'b0, bus0.out_ready}, 32'd1);
        check("w0_rd_rdata", bus0.out_rdata, 32'h5A5A5A5A);
        bus0.in_write = 1'b1; bus0.in_wdata = 32'h0;
        @(posedge clk); #1;
        check("w0_resp_ignored", {31'b0, bus0.out_ready}, 32'd0);
        bus0.in_request = 1'b0;
        bus0.in_write = 1'b0;
        @(negedge clk);
        bus0.in_request = 1'b1;
        @(posedge clk); #1;
        bus0.in_request = 1'b0;
        check("w0_word_kept", bus0.out_rdata, 32'h5A5A5A5A);
        @(posedge clk); #1;

        // Continuous request: accepted every second edge
        @(negedge clk);
        bus0.in_request = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rdy_pat[i] = bus0.out_ready;
        end
        bus0.in_request = 1'b0;
        check("w0_b2b_pattern", {24'b0, rdy_pat}, 32'h55);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
